// File: rtl/b11_stim_tx.sv
// Transmit side of the b11 x_in/stbi word interface: strobes one word
// into the scrambler, waits GAP cycles, then samples x_out as the result.
module b11_stim_tx #(
    parameter int unsigned GAP   = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       in_data,
    output logic             in_ready,
    output logic [5:0]       x_in,
    output logic             stbi,
    input  logic [5:0]       res_in,
    output logic             res_valid,
    output logic [5:0]       res_data,
    output logic             res_skip,
    output logic [CNT_W-1:0] tx_count
);

    typedef enum logic [2:0] {
        ST_WARM,
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam logic [7:0] WARM_LAST = 8'd1;
    localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [5:0]       x_in_q, x_in_d;
    logic             stbi_q, stbi_d;
    logic             in_ready_q, in_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [5:0]       res_data_q, res_data_d;
    logic             res_skip_q, res_skip_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic             word_skip;

    // The scrambler ignores words in 27..62, leaving x_out stale.
    assign word_skip = (x_in_q != 6'd0) && (x_in_q != 6'd63)
                    && (x_in_q > 6'd26);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_WARM;
            cnt_q       <= '0;
            x_in_q      <= '0;
            stbi_q      <= 1'b1;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_skip_q  <= 1'b0;
            tx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_in_q      <= x_in_d;
            stbi_q      <= stbi_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_skip_q  <= res_skip_d;
            tx_count_q  <= tx_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_in_d      = x_in_q;
        stbi_d      = 1'b1;
        in_ready_d  = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_skip_d  = res_skip_q;
        tx_count_d  = tx_count_q;
        unique case (state_q)
            ST_WARM: begin
                if (cnt_q == WARM_LAST) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    state_d    = ST_SEND;
                    x_in_d     = in_data;
                    tx_count_d = tx_count_q + CNT_W'(1);
                    stbi_d     = 1'b0;
                    in_ready_d = 1'b0;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == GAP_LAST) begin
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    res_valid_d = 1'b1;
                    res_data_d  = res_in;
                    res_skip_d  = word_skip;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_WARM;
                cnt_d   = '0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign x_in      = x_in_q;
    assign stbi      = stbi_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_skip  = res_skip_q;
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_b11_stim_tx.sv
// Random-stimulus bench for b11_stim_tx against an edge-indexed
// transaction model and a stand-in scrambler (x_out = word ^ 32).
module tb_b11_stim_tx;

    localparam int GAP = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;
    logic [5:0] res_in;
    logic       in_ready, stbi, res_valid, res_skip;
    logic [5:0] x_in, res_data;
    logic [7:0] tx_count;

    logic       in_ready2, stbi2, res_valid2, res_skip2;
    logic [5:0] x_in2, res_data2;
    logic [1:0] tx_count2;

    always #5 clock = ~clock;

    b11_stim_tx #(.GAP(GAP), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .x_in(x_in), .stbi(stbi), .res_in(res_in),
        .res_valid(res_valid), .res_data(res_data),
        .res_skip(res_skip), .tx_count(tx_count)
    );

    b11_stim_tx #(.GAP(GAP), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .x_in(x_in2), .stbi(stbi2), .res_in(res_in),
        .res_valid(res_valid2), .res_data(res_data2),
        .res_skip(res_skip2), .tx_count(tx_count2)
    );

    function automatic bit is_skip(logic [5:0] w);
        return (w != 6'd0) && (w != 6'd63) && (w > 6'd26);
    endfunction

    // Stand-in scrambler: takes the word while stbi is low.
    logic [5:0] scr_q = '0;
    assign res_in = scr_q;
    always @(posedge clock)
        if (!stbi && !is_skip(x_in)) scr_q <= x_in ^ 6'h20;

    int          n_checks = 0;
    int          n_fail = 0;
    int          e = 0;
    int          acc = -1000;
    int          ready_from = 1 << 30;
    int unsigned cnt = 0;
    logic [5:0]  w = '0;
    logic [5:0]  scr = '0;
    logic [5:0]  exp_x = '0;
    logic [5:0]  exp_data = '0;
    bit          exp_skip = 1'b0;
    bit          checks_on = 1'b0;
    logic [5:0]  dir_q[$];

    task automatic check_eq(string tag, logic [31:0] got,
                            logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, got, exp, e + 1);
        end
    endtask

    function automatic logic [5:0] pick_word();
        case ($urandom_range(0, 5))
            0: return 6'd0;
            1: return 6'd63;
            2: return 6'(26 + $urandom_range(0, 1));
            3: return 6'(61 + $urandom_range(0, 1));
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        int u;
        bit acc_now;
        dir_q.push_back(6'd5);
        dir_q.push_back(6'd0);
        dir_q.push_back(6'd63);
        dir_q.push_back(6'd40);
        dir_q.push_back(6'd27);
        dir_q.push_back(6'd26);
        dir_q.push_back(6'd62);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (checks_on) begin
                u = e + 1;
                check_eq("in_ready", 32'(in_ready),
                         32'(u >= ready_from));
                check_eq("stbi", 32'(stbi), 32'(u != acc + 1));
                check_eq("res_valid", 32'(res_valid),
                         32'(u == acc + GAP + 2));
                check_eq("x_in", 32'(x_in), 32'(exp_x));
                check_eq("res_data", 32'(res_data), 32'(exp_data));
                check_eq("res_skip", 32'(res_skip), 32'(exp_skip));
                check_eq("tx_count", 32'(tx_count), cnt % 256);
                check_eq("tx_count_w2", 32'(tx_count2), cnt % 4);
            end
            if (i < 3)
                reset = 1'b1;
            else if (i > 300 && $urandom_range(0, 149) == 0)
                reset = 1'b1;
            else
                reset = 1'b0;
            if (dir_q.size() > 0) begin
                in_valid = 1'b1;
                in_data  = dir_q[0];
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = pick_word();
            end
            @(posedge clock);
            e++;
            if (e == acc + 1 && !is_skip(w))
                scr = w ^ 6'h20;
            if (reset) begin
                checks_on  = 1'b1;
                ready_from = e + 3;
                acc        = -1000;
                exp_x      = '0;
                exp_data   = '0;
                exp_skip   = 1'b0;
                cnt        = 0;
            end else begin
                if (e == acc + GAP + 1) begin
                    exp_data = scr;
                    exp_skip = is_skip(w);
                end
                acc_now = in_valid && (e >= ready_from);
                if (acc_now) begin
                    acc        = e;
                    w          = in_data;
                    exp_x      = in_data;
                    cnt        = cnt + 1;
                    ready_from = e + GAP + 3;
                    if (dir_q.size() > 0)
                        void'(dir_q.pop_front());
                end
            end
        end
        if (dir_q.size() != 0) begin
            n_fail++;
            $display("FAIL directed_words: %0d left unaccepted",
                     dir_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
